// File: rtl/argmax_classifier.sv
// Argmax output stage: collects NUM_CLASSES serial scores, reports the winning
// class and its score on a valid/ready handshake, and buffers the score vector.
module argmax_classifier #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] score_in,
  input  logic                  score_valid,
  output logic [IDX_WIDTH-1:0]  class_out,
  output logic [DATA_WIDTH-1:0] max_score,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  drop_err,
  input  logic [7:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [8:0] NUM_CLASSES_W = 9'(NUM_CLASSES);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
  logic [IDX_WIDTH-1:0]  class_q, class_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic                  drop_err_q, drop_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] upd_max;
  logic [IDX_WIDTH-1:0]  upd_idx;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Running max including the current score; the first score of a set always wins.
  always_comb begin
    upd_max = run_max_q;
    upd_idx = run_idx_q;
    if (cnt_q == '0 || score_in > run_max_q) begin
      upd_max = score_in;
      upd_idx = cnt_q;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_max_d  = run_max_q;
    run_idx_d  = run_idx_q;
    class_d    = class_q;
    max_d      = max_q;
    drop_err_d = drop_err_q;
    wr_en      = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (score_valid) begin
          wr_en     = 1'b1;
          run_max_d = upd_max;
          run_idx_d = upd_idx;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            class_d = upd_idx;
            max_d   = upd_max;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (score_valid) drop_err_d = 1'b1;
        if (result_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      run_max_q  <= '0;
      run_idx_q  <= '0;
      class_q    <= '0;
      max_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_max_q  <= run_max_d;
      run_idx_q  <= run_idx_d;
      class_q    <= class_d;
      max_q      <= max_d;
      drop_err_q <= drop_err_d;
    end
  end

  // NOTE: the score buffer has no reset; its contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[cnt_q] <= score_in;
  end

  // Read sees the pre-write contents when addresses collide in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if ({1'b0, rd_addr} < NUM_CLASSES_W) begin
      rd_data_q <= mem_q[IDX_WIDTH'(rd_addr)];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign class_out    = class_q;
  assign max_score    = max_q;
  assign result_valid = (state_q == HOLD);
  assign busy         = (state_q == COLLECT) && (cnt_q != '0);
  assign drop_err     = drop_err_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: directed score sets with hand-computed
// winners; a negedge monitor checks every accepted result against the queue.
module tb_argmax_classifier;

  logic        clk;
  logic        rst_n;
  logic [15:0] score_in;
  logic        score_valid;
  logic [3:0]  class_out;
  logic [15:0] max_score;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        drop_err;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;

  typedef logic [15:0] set_t [10];
  typedef struct packed {
    logic [3:0]  cls;
    logic [15:0] mx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  argmax_classifier #(.DATA_WIDTH(16), .NUM_CLASSES(10), .IDX_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .score_in     (score_in),
    .score_valid  (score_valid),
    .class_out    (class_out),
    .max_score    (max_score),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .drop_err     (drop_err),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a handshake completes at the next rising edge, so pop it here.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: got result class %0d score 0x%0h with nothing expected",
                 class_out, max_score);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("class_out", 32'(class_out), 32'(e.cls));
        check("max_score", 32'(max_score), 32'(e.mx));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_set(input set_t s, input logic [3:0] cls, input logic [15:0] mx,
                          input bit push);
    if (push) sb.push_back('{cls: cls, mx: mx});
    for (int i = 0; i < 10; i++) begin
      score_in    = s[i];
      score_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i < 9) check("busy_mid_set", 32'(busy), 32'd1);
    end
    score_valid = 1'b0;
    check("valid_after_last", 32'(result_valid), 32'd1);
    check("busy_after_last", 32'(busy), 32'd0);
  endtask

  task automatic readback(input set_t s);
    for (int a = 0; a < 10; a++) begin
      rd_addr = 8'(a);
      @(posedge clk);
      #1;
      check("rd_data", 32'(rd_data), 32'(s[a]));
    end
    rd_addr = 8'd10;
    @(posedge clk);
    #1;
    check("rd_data_addr10", 32'(rd_data), 32'd0);
    rd_addr = 8'd255;
    @(posedge clk);
    #1;
    check("rd_data_addr255", 32'(rd_data), 32'd0);
    rd_addr = 8'd0;
  endtask

  initial begin
    set_t a_set, tie_set, zero_set, b_set, c_set, d_set, e_set, f_set, g_set, h_set;
    a_set    = '{16'h0100, 16'h0800, 16'h0200, 16'h7FFF, 16'h0001,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000};
    tie_set  = '{16'h0010, 16'h0010, 16'h0400, 16'h0010, 16'h0010,
                 16'h0010, 16'h0010, 16'h0400, 16'h0010, 16'h0010};
    zero_set = '{default: 16'h0000};
    b_set    = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055,
                 16'h6000, 16'h0066, 16'h0077, 16'h0088, 16'h0099};
    c_set    = '{16'h0200, 16'h0100, 16'h0300, 16'h0050, 16'h0300,
                 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0001};
    d_set    = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0500};
    e_set    = '{16'h0006, 16'h0005, 16'h0005, 16'h0005, 16'h0005,
                 16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005};
    f_set    = '{16'h3000, 16'h2FFF, 16'h0001, 16'h0002, 16'h0003,
                 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h2FFF};
    g_set    = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                 16'h0006, 16'h7FFE, 16'h0008, 16'h0009, 16'h000A};
    h_set    = '{16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};

    rst_n        = 1'b0;
    score_in     = '0;
    score_valid  = 1'b0;
    result_ready = 1'b1;
    rd_addr      = 8'd0;
    idle(2);

    // Reset state
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_class_out", 32'(class_out), 32'd0);
    check("rst_max_score", 32'(max_score), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Basic set; result_valid must be a single-cycle pulse with ready held high
    send_set(a_set, 4'd3, 16'h7FFF, 1'b1);
    idle(1);
    check("valid_pulse_end", 32'(result_valid), 32'd0);
    check("drop_err_basic", 32'(drop_err), 32'd0);
    readback(a_set);

    // Ties keep the lower index; all-zero set yields class 0
    idle(1);
    send_set(tie_set, 4'd2, 16'h0400, 1'b1);
    idle(2);
    send_set(zero_set, 4'd0, 16'h0000, 1'b1);
    idle(2);

    // Backpressure with a dropped score in HOLD
    result_ready = 1'b0;
    send_set(b_set, 4'd5, 16'h6000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        score_in    = 16'h7FFF;
        score_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      score_valid = 1'b0;
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_class", 32'(class_out), 32'd5);
      check("hold_max", 32'(max_score), 32'h6000);
      if (i >= 10) check("drop_err_sticky", 32'(drop_err), 32'd1);
    end
    result_ready = 1'b1;
    idle(2);
    check("drop_err_after_hs", 32'(drop_err), 32'd1);
    send_set(c_set, 4'd2, 16'h0300, 1'b1);
    idle(1);
    readback(c_set);
    check("drop_err_still", 32'(drop_err), 32'd1);

    // Reset mid-collection discards the partial set
    for (int i = 0; i < 5; i++) begin
      score_in    = 16'h7000;
      score_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    score_valid = 1'b0;
    check("busy_partial", 32'(busy), 32'd1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("busy_after_rst", 32'(busy), 32'd0);
    check("drop_err_cleared", 32'(drop_err), 32'd0);
    send_set(d_set, 4'd9, 16'h0500, 1'b1);
    idle(2);

    // Reset during HOLD drops the pending result
    result_ready = 1'b0;
    send_set(e_set, 4'd0, 16'h0006, 1'b0);
    idle(1);
    check("hold_before_rst", 32'(result_valid), 32'd1);
    rst_n = 1'b0;
    idle(1);
    check("valid_after_hold_rst", 32'(result_valid), 32'd0);
    check("class_after_hold_rst", 32'(class_out), 32'd0);
    check("max_after_hold_rst", 32'(max_score), 32'd0);
    rst_n        = 1'b1;
    result_ready = 1'b1;
    idle(1);

    // Streaming: three sets with two-cycle gaps
    send_set(f_set, 4'd0, 16'h3000, 1'b1);
    idle(2);
    send_set(g_set, 4'd6, 16'h7FFE, 1'b1);
    idle(2);
    send_set(h_set, 4'd8, 16'hFFFF, 1'b1);
    idle(3);
    check("drop_err_stream", 32'(drop_err), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
# argmax_classifier

Output stage of the network. Consumes the serial stream of final-layer neuron results, one score per `score_valid` pulse. Each score is unsigned Q1.15 (post-ReLU, never negative). After `NUM_CLASSES` scores it presents the winning class index and its score on a valid/ready handshake. It also keeps the full score vector in a small buffer that can be read back for debug or softmax post-processing.

## Interface
Parameters:
- `DATA_WIDTH`, 16, score width (Q1.15 bit pattern, treated as unsigned)
- `NUM_CLASSES`, 10, scores per inference; legal range 2..256
- `IDX_WIDTH`, 4, class index width; must satisfy 2^IDX_WIDTH >= NUM_CLASSES

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `score_in` in DATA_WIDTH: neuron result
- `score_valid` in 1: single-cycle pulse qualifying `score_in`. There is no backpressure.
- `class_out` out IDX_WIDTH: index of the maximum score
- `max_score` out DATA_WIDTH: value of the maximum score
- `result_valid` out 1: result available
- `result_ready` in 1: consumer accepts the result
- `busy` out 1: high while at least one score of the current set has been accepted
- `drop_err` out 1: sticky; a score arrived while a result was pending
- `rd_addr` in 8: score buffer read address
- `rd_data` out DATA_WIDTH: buffer read data, one-cycle latency

## Operation
- Two states:
  - COLLECT (the reset state)
  - HOLD
- COLLECT, on `score_valid`:
  - Write `score_in` to `buf[cnt]`.
  - Compare against the running max.
  - Increment `cnt`.
- Running max rules:
  - The first score of a set (`cnt == 0`) loads `run_max = score_in`, `run_idx = 0` unconditionally.
  - Later scores replace the max only if `score_in > run_max`, compared unsigned.
  - Ties keep the lower index.
- Set completion: on the score with `cnt == NUM_CLASSES-1`, the following all happen in that same cycle:
  - the max update includes the current score;
  - `class_out` and `max_score` are loaded from the updated max;
  - `cnt` returns to 0;
  - the state moves to HOLD.
- HOLD:
  - `result_valid` = 1.
  - `class_out` and `max_score` stay stable until the handshake.
  - When `result_valid && result_ready` at a rising edge, the state returns to COLLECT.
- Scores in HOLD: any `score_valid` in HOLD is discarded, including the handshake cycle.
  - Neither the buffer nor `cnt` changes.
  - `drop_err` is set and stays set until reset.
- `busy` = (`cnt != 0`) in COLLECT; 0 in HOLD.
- Buffer readback:
  - `rd_data` is registered from `buf[rd_addr]` every cycle in either state.
  - If `rd_addr >= NUM_CLASSES`, `rd_data` returns 0.
  - A read and write to the same address in the same cycle returns the old contents.
- `result_ready` outside HOLD is ignored.

## Timing
- Reset, when `rst_n` is 0 at a rising edge:
  - outputs: `class_out`, `max_score`, `result_valid`, `busy`, `drop_err`, `rd_data` all go to 0;
  - internal: `cnt` = 0, `run_max` = 0, `run_idx` = 0, state = COLLECT.
  - Buffer contents need not be cleared.
- Reset mid-collection discards the partial set. Reset in HOLD drops the pending result.
- Latency: last score accepted at edge N gives `result_valid` = 1 after edge N. A consumer holding `result_ready` = 1 completes the handshake at edge N+1.
- The earliest the next set's first score is accepted is edge N+2. A score pulse at edge N+1 falls in HOLD and is dropped.
- Back-to-back `score_valid` every cycle is supported in COLLECT. One result is produced per `NUM_CLASSES` accepted scores.
- `busy` and `result_valid` are registered outputs with no combinational path from inputs.
- `rd_data` updates at the edge after `rd_addr` is sampled.

## Test plan
- Reset, then scores 0x0100,0x0800,0x0200,0x7FFF,0x0001,0,0,0,0,0x1000, with `result_ready` = 1:
  - `result_valid` pulses one cycle with `class_out` = 3, `max_score` = 0x7FFF;
  - `busy` is 1 from the first score until completion;
  - `drop_err` = 0.
- Tie: scores with value 0x0400 at indices 2 and 7, all others 0x0010 → `class_out` = 2. All-zero set → `class_out` = 0, `max_score` = 0.
- Backpressure:
  - Hold `result_ready` = 0 for 20 cycles after completion: `result_valid`, `class_out` and `max_score` stay stable.
  - Inject a `score_valid` pulse during HOLD: `drop_err` = 1 and stays 1.
  - The next full set then yields the correct result, and the buffer holds the new set.
- Readback: after a set, read `rd_addr` 0..9 → `rd_data` matches each score one cycle later. `rd_addr` = 10 and 255 → 0.
- Reset mid-operation:
  - Pulse `rst_n` low after 5 scores, then send a fresh 10-score set with the max at index 9: result `class_out` = 9, with no contamination from the earlier scores.
  - Reset during HOLD clears `result_valid` on the next cycle.
- Streaming: three back-to-back sets with gaps ≥ 2 cycles between sets and `result_ready` tied to 1 → three correct results, `drop_err` = 0.
